// File: rtl/ex_muldiv_seq.sv
// ---------------------------------------------------------------------------
// ex_muldiv_seq
//   Sequencer for the EX-stage multi-cycle unit. Accepts one MUL/DIV op from
//   EX, runs a MUL_LAT-cycle multiplier or a radix-2 restoring divider (one
//   quotient bit per cycle), and returns a registered 32-bit result with a
//   one-cycle done pulse. Drives EX's multi-cycle stall term and honours
//   pipeline flush.
//
// Ports
//   clk        clock
//   rst_n      synchronous, active-low reset
//   flush      EX flush; kills any in-flight op, blocks accept
//   req_valid  EX holds a MUL/DIV op (held stable while stall=1)
//   req_op     0 MUL_W, 1 MULH_W, 2 MULH_WU, 3 DIV_W, 4 MOD_W,
//              5 DIV_WU, 6 MOD_WU, 7 reserved
//   src_a      forwarded rj value
//   src_b      forwarded rk value
//   stall      combinational: req_valid & ~flush & ~done
//   done       registered one-cycle pulse, result valid this cycle
//   result     registered result, held until the next done
//   busy       unit is not idle
// ---------------------------------------------------------------------------
module ex_muldiv_seq #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        busy
);

  localparam int CNT_MAX = (DIV_ITER > MUL_LAT) ? DIV_ITER : MUL_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0] OP_MUL_W   = 3'd0;
  localparam logic [2:0] OP_MULH_W  = 3'd1;
  localparam logic [2:0] OP_MULH_WU = 3'd2;
  localparam logic [2:0] OP_DIV_W   = 3'd3;
  localparam logic [2:0] OP_MOD_W   = 3'd4;
  localparam logic [2:0] OP_MOD_WU  = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [63:0]       prod_q, prod_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [31:0]       dvs_q, dvs_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              done_q, done_d;
  logic [31:0]       result_q, result_d;

  // Request decode, evaluated on the incoming op at accept time.
  logic is_mul_op, is_div_op, is_signed_div, is_rem_op;
  logic div_by_zero, div_ovf, is_special;

  assign is_mul_op     = (req_op <= OP_MULH_WU);
  assign is_div_op     = (req_op >= OP_DIV_W) && (req_op <= OP_MOD_WU);
  assign is_signed_div = (req_op == OP_DIV_W) || (req_op == OP_MOD_W);
  assign is_rem_op     = (req_op == OP_MOD_W) || (req_op == OP_MOD_WU);
  assign div_by_zero   = is_div_op && (src_b == 32'd0);
  assign div_ovf       = is_signed_div && (src_a == 32'h8000_0000) &&
                         (src_b == 32'hFFFF_FFFF);
  assign is_special    = (req_op == OP_RSVD) || div_by_zero || div_ovf;

  // Results that bypass the iterative divider entirely.
  logic [31:0] special_res;

  always_comb begin
    special_res = 32'd0;
    if (div_by_zero) begin
      special_res = is_rem_op ? src_a : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_res = is_rem_op ? 32'd0 : 32'h8000_0000;
    end
  end

  // Only MULH_W treats its operands as signed. The low word is the same for
  // either signedness, so MUL_W uses the zero-extended form. Extending to
  // 64 bits makes a plain unsigned multiply give the correct 64-bit product.
  logic        mul_sext;
  logic [63:0] mul_a_ext, mul_b_ext, mul_prod;

  assign mul_sext  = (req_op == OP_MULH_W);
  assign mul_a_ext = {{32{mul_sext & src_a[31]}}, src_a};
  assign mul_b_ext = {{32{mul_sext & src_b[31]}}, src_b};
  assign mul_prod  = mul_a_ext * mul_b_ext;

  // Signed divides run on magnitudes; sign is restored when the result loads.
  logic [31:0] a_mag, b_mag;

  assign a_mag = (is_signed_div && src_a[31]) ? -src_a : src_a;
  assign b_mag = (is_signed_div && src_b[31]) ? -src_b : src_b;

  // One restoring-division step: shift the next dividend bit into the partial
  // remainder and subtract the divisor. A borrow (bit 32) means restore.
  logic [32:0] div_shift, div_diff;
  logic [31:0] div_rem_nxt, div_quo_nxt, quo_fix, rem_fix;

  assign div_shift   = {rem_q, quo_q[31]};
  assign div_diff    = div_shift - {1'b0, dvs_q};
  assign div_rem_nxt = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
  assign div_quo_nxt = {quo_q[30:0], ~div_diff[32]};
  assign quo_fix     = quo_neg_q ? -div_quo_nxt : div_quo_nxt;
  assign rem_fix     = rem_neg_q ? -div_rem_nxt : div_rem_nxt;

  // Next-state and datapath. Flush, or EX dropping req_valid mid-op,
  // abandons the operation without a done pulse and leaves result untouched.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          op_d = req_op;
          if (is_mul_op) begin
            prod_d  = mul_prod;
            cnt_d   = CNT_W'(MUL_LAT - 1);
            state_d = S_MUL;
          end else if (is_special) begin
            result_d = special_res;
            state_d  = S_FIN;
          end else begin
            rem_d     = 32'd0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            quo_neg_d = is_signed_div && (src_a[31] ^ src_b[31]);
            rem_neg_d = is_signed_div && src_a[31];
            cnt_d     = CNT_W'(DIV_ITER - 1);
            state_d   = S_DIV;
          end
        end
      end

      S_MUL: begin
        if (flush || !req_valid) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          result_d = (op_q == OP_MUL_W) ? prod_q[31:0] : prod_q[63:32];
          state_d  = S_FIN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DIV: begin
        if (flush || !req_valid) begin
          state_d = S_IDLE;
        end else begin
          rem_d = div_rem_nxt;
          quo_d = div_quo_nxt;
          if (cnt_q == '0) begin
            result_d = ((op_q == OP_MOD_W) || (op_q == OP_MOD_WU)) ? rem_fix : quo_fix;
            state_d  = S_FIN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      // The op still on req_valid here is the one just finished; EX advances
      // this cycle, so it must not be accepted again.
      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= 3'd0;
      prod_q    <= 64'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign stall  = req_valid & ~flush & ~done_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = (state_q != S_IDLE);

endmodule
